// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
//
// Purpose: groups the writeback request, hazard-query and register-file
// write-port signals of wb_arbiter into one bundle.
//
// Handshake: the ALU writeback (alu_valid/alu_rd/alu_data) has no ready and
// is always taken in the cycle it is presented. A memory writeback transfers
// on a rising clock edge where mem_valid && mem_ready are both high. The
// requester must hold mem_valid/mem_rd/mem_data stable until that edge, and
// mem_ready never depends on mem_valid.
//
// Signal summary:
//   alu_valid/alu_rd/alu_data  ALU writeback request          (master -> slave)
//   mem_valid/mem_rd/mem_data  memory writeback request       (master -> slave)
//   mem_ready                  memory request accepted        (slave -> master)
//   rs1/rs2                    decode source indices to query (master -> slave)
//   rs1_pending/rs2_pending    live queued write targets rsN  (slave -> master)
//   WE3/AD3/WD3                registered register-file write (slave -> master)
//   fifo_level                 occupied queue entries         (slave -> master)
//   fwd1_hit/fwd2_hit          WD3 usable as rsN bypass       (WB_FORWARD_EN only)
//
// Optional feature macro: WB_FORWARD_EN adds fwd1_hit/fwd2_hit.
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                     alu_valid;
    logic [ADDRESS_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;

    logic                     mem_valid;
    logic                     mem_ready;
    logic [ADDRESS_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0]    mem_data;

    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic                     rs1_pending;
    logic                     rs2_pending;

    logic                     WE3;
    logic [ADDRESS_WIDTH-1:0] AD3;
    logic [DATA_WIDTH-1:0]    WD3;
    logic [LVL_W-1:0]         fifo_level;

`ifdef WB_FORWARD_EN
    logic                     fwd1_hit;
    logic                     fwd2_hit;

    // CPU side: issues writebacks and queries hazards.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output rs1, rs2,
        input  mem_ready, rs1_pending, rs2_pending,
        input  WE3, AD3, WD3, fifo_level,
        input  fwd1_hit, fwd2_hit
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  rs1, rs2,
        output mem_ready, rs1_pending, rs2_pending,
        output WE3, AD3, WD3, fifo_level,
        output fwd1_hit, fwd2_hit
    );
`else
    // CPU side: issues writebacks and queries hazards.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output rs1, rs2,
        input  mem_ready, rs1_pending, rs2_pending,
        input  WE3, AD3, WD3, fifo_level
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  rs1, rs2,
        output mem_ready, rs1_pending, rs2_pending,
        output WE3, AD3, WD3, fifo_level
    );
`endif

endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Purpose: write-side controller for the CPU register file write port
// (AD3/WD3/WE3). Single-cycle ALU results and variable-latency load results
// share the one write port. ALU results always win the port. Load results
// that cannot issue immediately wait in a small in-order queue. Writes to x0
// are dropped, and decode is told which source registers still have a live
// queued write outstanding.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   wb_arbiter_if.slave (see the interface for the signal list)
//
// Selection each cycle, highest priority first:
//   1. ALU request                  -> issue ALU write
//   2. queue not empty              -> pop head (write only if live, rd != 0)
//   3. memory request, queue empty  -> bypass straight to the write port
//   4. nothing                      -> WE3 = 0, AD3/WD3 hold
//
// Each queue slot carries a "dead" bit. An ALU write to rd kills every queued
// write to the same rd, so a younger ALU result is never overwritten by an
// older load. Dead slots still drain through the port as WE3 = 0 cycles,
// which keeps the queue a plain ring buffer.
//
// Optional feature macro: WB_FORWARD_EN. When defined, fwd1_hit/fwd2_hit flag
// that the write currently on WE3/AD3/WD3 targets rs1/rs2. Decode can then
// take WD3 instead of the stale register-file read.
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] rd_q   [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] rd_d   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    used_q, used_d;   // slot holds an entry
    logic [FIFO_DEPTH-1:0]    dead_q, dead_d;   // entry must not write
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         count_q, count_d;

    logic                     we3_q, we3_d;
    logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
    logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

    // ---------------------------------------------------------------------
    // Decisions for this cycle
    // ---------------------------------------------------------------------
    logic full;
    logic empty;
    logic mem_acc;     // memory handshake completes this edge
    logic sel_pop;     // queue head owns the port
    logic sel_byp;     // memory request goes straight to the port
    logic push;        // accepted memory request enters the queue
    logic alu_kill;    // ALU write that shadows older queued writes
    logic push_dead;   // entry being pushed is already shadowed
    logic head_live;   // head slot would produce a real write

    always_comb begin
        full      = (count_q == FULL_LVL);
        empty     = (count_q == '0);
        mem_acc   = bus.mem_valid && !full;
        sel_pop   = !bus.alu_valid && !empty;
        sel_byp   = !bus.alu_valid && empty && bus.mem_valid;
        push      = mem_acc && !sel_byp;
        alu_kill  = bus.alu_valid && (bus.alu_rd != '0);
        // The ALU request is the younger instruction, so a same-rd load that
        // arrives in the same cycle must never reach the register file.
        push_dead = (bus.mem_rd == '0) || (alu_kill && (bus.mem_rd == bus.alu_rd));
        head_live = used_q[rd_ptr_q] && !dead_q[rd_ptr_q] && (rd_q[rd_ptr_q] != '0);
    end

    // ---------------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------------
    always_comb begin
        rd_d     = rd_q;
        data_d   = data_q;
        used_d   = used_q;
        dead_d   = dead_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we3_d    = 1'b0;
        ad3_d    = ad3_q;
        wd3_d    = wd3_q;

        // Kill shadowed entries. The head is included: it is never popped in
        // an ALU cycle, so it is still being held here.
        if (alu_kill) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (used_q[i] && (rd_q[i] == bus.alu_rd)) begin
                    dead_d[i] = 1'b1;
                end
            end
        end

        if (sel_pop) begin
            used_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        // The push slot can never be the popped slot: a pop needs a non-empty
        // queue, and a push needs a non-full one, so the pointers differ.
        if (push) begin
            rd_d[wr_ptr_q]   = bus.mem_rd;
            data_d[wr_ptr_q] = bus.mem_data;
            used_d[wr_ptr_q] = 1'b1;
            dead_d[wr_ptr_q] = push_dead;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + LVL_W'(push) - LVL_W'(sel_pop);

        if (bus.alu_valid) begin
            we3_d = (bus.alu_rd != '0);
            ad3_d = bus.alu_rd;
            wd3_d = bus.alu_data;
        end else if (sel_pop) begin
            // Dead heads still drive AD3/WD3 so the drain is visible.
            we3_d = head_live;
            ad3_d = rd_q[rd_ptr_q];
            wd3_d = data_q[rd_ptr_q];
        end else if (sel_byp) begin
            we3_d = (bus.mem_rd != '0);
            ad3_d = bus.mem_rd;
            wd3_d = bus.mem_data;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= '{default: '0};
            data_q   <= '{default: '0};
            used_q   <= '0;
            dead_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we3_q    <= 1'b0;
            ad3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            rd_q     <= rd_d;
            data_q   <= data_d;
            used_q   <= used_d;
            dead_q   <= dead_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we3_q    <= we3_d;
            ad3_q    <= ad3_d;
            wd3_q    <= wd3_d;
        end
    end

    // ---------------------------------------------------------------------
    // Hazard query: only live queued writes count. The write currently on
    // the port is excluded, because the register file has no write-through.
    // ---------------------------------------------------------------------
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (used_q[i] && !dead_q[i]) begin
                if (rd_q[i] == bus.rs1) rs1_hit = 1'b1;
                if (rd_q[i] == bus.rs2) rs2_hit = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.mem_ready   = !full;
    assign bus.rs1_pending = rs1_hit && (bus.rs1 != '0);
    assign bus.rs2_pending = rs2_hit && (bus.rs2 != '0);
    assign bus.WE3         = we3_q;
    assign bus.AD3         = ad3_q;
    assign bus.WD3         = wd3_q;
    assign bus.fifo_level  = count_q;

`ifdef WB_FORWARD_EN
    assign bus.fwd1_hit = we3_q && (ad3_q == bus.rs1) && (bus.rs1 != '0);
    assign bus.fwd2_hit = we3_q && (ad3_q == bus.rs2) && (bus.rs2 != '0);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter: directed scenarios plus randomized traffic for wb_arbiter.
// Expected results come from a queue-based model of the writeback rules.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic          dead;
    } ent_t;

    ent_t          mq[$];
    logic          exp_we;
    logic [AW-1:0] exp_ad;
    logic [DW-1:0] exp_wd;

    logic          cur_av, cur_mv;
    logic [AW-1:0] cur_ar, cur_mr;
    logic [DW-1:0] cur_ad, cur_md;

    function automatic logic model_pending(input logic [AW-1:0] rs);
        if (rs == '0) return 1'b0;
        foreach (mq[i]) if (!mq[i].dead && mq[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        ent_t e;
        logic acc;
        acc = cur_mv && (mq.size() < DEPTH);
        if (cur_av) begin
            exp_we = (cur_ar != '0);
            exp_ad = cur_ar;
            exp_wd = cur_ad;
            if (cur_ar != '0) foreach (mq[i]) if (mq[i].rd == cur_ar) mq[i].dead = 1'b1;
            if (acc) begin
                e.rd = cur_mr; e.data = cur_md;
                e.dead = (cur_mr == '0) || (cur_mr == cur_ar);
                mq.push_back(e);
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = !e.dead && (e.rd != '0);
            exp_ad = e.rd;
            exp_wd = e.data;
            if (acc) begin
                e.rd = cur_mr; e.data = cur_md; e.dead = (cur_mr == '0);
                mq.push_back(e);
            end
        end else if (cur_mv) begin
            exp_we = (cur_mr != '0);
            exp_ad = cur_mr;
            exp_wd = cur_md;
        end else begin
            exp_we = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_rs(input logic [AW-1:0] a, input logic [AW-1:0] b);
        bus.rs1 = a;
        bus.rs2 = b;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        cur_av = av; cur_ar = ar; cur_ad = ad;
        cur_mv = mv; cur_mr = mr; cur_md = md;
        bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_rd = mr; bus.mem_data = md;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        exp_we = 1'b0; exp_ad = '0; exp_wd = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_rs(AW'(5), '0);
        do_reset();
        n_checks++;
        if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b0, {AW{1'b0}}, {DW{1'b0}}})
            $display("FAIL reset_port: got we=%0b ad=%0d wd=%h, expected 0/0/0", bus.WE3, bus.AD3, bus.WD3);
        else n_pass++;
        n_checks++;
        if (bus.fifo_level !== LW'(0) || bus.mem_ready !== 1'b1)
            $display("FAIL reset_fifo: got level=%0d ready=%0b, expected 0/1", bus.fifo_level, bus.mem_ready);
        else n_pass++;

        for (int k = 0; k < 3; k++) begin
            drive(1'b1, AW'(k + 1), DW'(k), 1'b1, AW'(5 + k), DW'(100 + k));
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_checks++;
        if (bus.fifo_level !== LW'(3) || bus.rs1_pending !== 1'b1)
            $display("FAIL reset_prefill: got level=%0d pend=%0b, expected 3/1", bus.fifo_level, bus.rs1_pending);
        else n_pass++;

        do_reset();
        n_checks++;
        if ({bus.fifo_level, bus.WE3, bus.mem_ready, bus.rs1_pending} !== {LW'(0), 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_midqueue: got level=%0d we=%0b ready=%0b pend=%0b, expected 0/0/1/0",
                     bus.fifo_level, bus.WE3, bus.mem_ready, bus.rs1_pending);
        else n_pass++;
    endtask

    task automatic test_bypass();
        drive(1'b0, '0, '0, 1'b1, AW'(7), 32'hDEADBEEF);
        tick();
        n_checks++;
        if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b1, AW'(7), 32'hDEADBEEF})
            $display("FAIL bypass_write: got we=%0b ad=%0d wd=%h, expected 1/7/deadbeef", bus.WE3, bus.AD3, bus.WD3);
        else n_pass++;
        n_checks++;
        if (bus.fifo_level !== LW'(0))
            $display("FAIL bypass_level: got %0d, expected 0", bus.fifo_level);
        else n_pass++;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        n_checks++;
        if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b0, AW'(7), 32'hDEADBEEF})
            $display("FAIL bypass_idle_hold: got we=%0b ad=%0d wd=%h, expected 0/7/deadbeef", bus.WE3, bus.AD3, bus.WD3);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [AW+DW-1:0] exp_q[$];
        int m = 0;
        logic acc;
        for (int k = 1; k <= 5; k++) exp_q.push_back({AW'(k), DW'(32'hB000 + k - 1)});
        for (int k = 0; k < 5; k++) exp_q.push_back({AW'(10 + k), DW'(32'hA000 + k)});
        for (int c = 0; c < 10; c++) begin
            drive(c < 5, (c < 5) ? AW'(c + 1) : '0, (c < 5) ? DW'(32'hB000 + c) : '0,
                  m < 5, AW'(10 + m), DW'(32'hA000 + m));
            if (c == 4) begin
                n_checks++;
                if (bus.mem_ready !== 1'b0 || bus.fifo_level !== LW'(4))
                    $display("FAIL contention_full: got ready=%0b level=%0d, expected 0/4", bus.mem_ready, bus.fifo_level);
                else n_pass++;
            end
            acc = cur_mv && (mq.size() < DEPTH);
            tick();
            if (acc) m++;
            n_checks++;
            if (exp_q.size() == 0)
                $display("FAIL contention_order: got extra write ad=%0d, expected none", bus.AD3);
            else if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b1, exp_q[0]})
                $display("FAIL contention_order: got we=%0b ad=%0d wd=%h, expected 1/%0d/%h",
                         bus.WE3, bus.AD3, bus.WD3, exp_q[0][AW+DW-1:DW], exp_q[0][DW-1:0]);
            else n_pass++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_checks++;
        if (bus.fifo_level !== LW'(0) || bus.mem_ready !== 1'b1)
            $display("FAIL contention_drain: got level=%0d ready=%0b, expected 0/1", bus.fifo_level, bus.mem_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_waw();
        set_rs(AW'(9), AW'(8));
        drive(1'b1, AW'(3), 32'h33, 1'b1, AW'(9), 32'h11);
        tick();
        drive(1'b1, AW'(9), 32'h22, 1'b0, '0, '0);
        n_checks++;
        if (bus.rs1_pending !== 1'b1)
            $display("FAIL waw_pending_before: got %0b, expected 1", bus.rs1_pending);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.WE3, bus.AD3, bus.WD3, bus.rs1_pending} !== {1'b1, AW'(9), 32'h22, 1'b0})
            $display("FAIL waw_alu_write: got we=%0b ad=%0d wd=%h pend=%0b, expected 1/9/22/0",
                     bus.WE3, bus.AD3, bus.WD3, bus.rs1_pending);
        else n_pass++;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        n_checks++;
        if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b0, AW'(9), 32'h11})
            $display("FAIL waw_dead_pop: got we=%0b ad=%0d wd=%h, expected 0/9/11", bus.WE3, bus.AD3, bus.WD3);
        else n_pass++;
        // Same-cycle ALU and memory to one rd: the load is pushed dead.
        drive(1'b1, AW'(8), 32'h44, 1'b1, AW'(8), 32'h88);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_checks++;
        if ({bus.rs2_pending, bus.fifo_level} !== {1'b0, LW'(1)})
            $display("FAIL waw_same_cycle: got pend=%0b level=%0d, expected 0/1", bus.rs2_pending, bus.fifo_level);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b0, AW'(8), 32'h88})
            $display("FAIL waw_same_cycle_pop: got we=%0b ad=%0d wd=%h, expected 0/8/88", bus.WE3, bus.AD3, bus.WD3);
        else n_pass++;
    endtask

    task automatic test_x0();
        set_rs('0, '0);
        drive(1'b1, '0, 32'h5, 1'b1, '0, 32'h6);
        n_checks++;
        if (bus.rs1_pending !== 1'b0)
            $display("FAIL x0_pending_pre: got %0b, expected 0", bus.rs1_pending);
        else n_pass++;
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_checks++;
        if ({bus.WE3, bus.rs1_pending, bus.fifo_level} !== {1'b0, 1'b0, LW'(1)})
            $display("FAIL x0_alu: got we=%0b pend=%0b level=%0d, expected 0/0/1", bus.WE3, bus.rs1_pending, bus.fifo_level);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b0, AW'(0), 32'h6})
            $display("FAIL x0_pop: got we=%0b ad=%0d wd=%h, expected 0/0/6", bus.WE3, bus.AD3, bus.WD3);
        else n_pass++;
        drive(1'b0, '0, '0, 1'b1, '0, 32'h7);
        tick();
        n_checks++;
        if ({bus.WE3, bus.WD3, bus.fifo_level} !== {1'b0, 32'h7, LW'(0)})
            $display("FAIL x0_bypass: got we=%0b wd=%h level=%0d, expected 0/7/0", bus.WE3, bus.WD3, bus.fifo_level);
        else n_pass++;
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        set_rs('0, '0);
        drive(1'b1, AW'(4), 32'h55, 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        set_rs(AW'(4), '0);
        #1;
        n_checks++;
        if ({bus.fwd1_hit, bus.fwd2_hit, bus.WD3} !== {1'b1, 1'b0, 32'h55})
            $display("FAIL fwd_hit: got f1=%0b f2=%0b wd=%h, expected 1/0/55", bus.fwd1_hit, bus.fwd2_hit, bus.WD3);
        else n_pass++;
        set_rs('0, AW'(4));
        #1;
        n_checks++;
        if ({bus.fwd1_hit, bus.fwd2_hit} !== 2'b01)
            $display("FAIL fwd_rs0: got f1=%0b f2=%0b, expected 0/1", bus.fwd1_hit, bus.fwd2_hit);
        else n_pass++;
        tick();
    endtask
`endif

    task automatic test_random();
        logic          pend_v = 1'b0;
        logic [AW-1:0] pend_rd = '0;
        logic [DW-1:0] pend_d = '0;
        logic          acc;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
                pend_v = 1'b0;
                n_checks++;
                if ({bus.WE3, bus.fifo_level} !== {1'b0, LW'(0)})
                    $display("FAIL rand_reset: got we=%0b level=%0d, expected 0/0", bus.WE3, bus.fifo_level);
                else n_pass++;
            end
            if (!pend_v && $urandom_range(0, 2) != 0) begin
                pend_v  = 1'b1;
                pend_rd = AW'($urandom_range(0, 7));
                pend_d  = $urandom;
            end
            set_rs(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom,
                  pend_v, pend_rd, pend_d);
            n_checks++;
            if ({bus.mem_ready, bus.fifo_level, bus.rs1_pending, bus.rs2_pending} !==
                {mq.size() < DEPTH, LW'(mq.size()), model_pending(bus.rs1), model_pending(bus.rs2)})
                $display("FAIL rand_status c=%0d: got ready=%0b level=%0d p1=%0b p2=%0b, expected %0b/%0d/%0b/%0b",
                         c, bus.mem_ready, bus.fifo_level, bus.rs1_pending, bus.rs2_pending,
                         mq.size() < DEPTH, mq.size(), model_pending(bus.rs1), model_pending(bus.rs2));
            else n_pass++;
            acc = pend_v && (mq.size() < DEPTH);
            tick();
            if (acc) pend_v = 1'b0;
            n_checks++;
            if ({bus.WE3, bus.AD3, bus.WD3} !== {exp_we, exp_ad, exp_wd})
                $display("FAIL rand_port c=%0d: got we=%0b ad=%0d wd=%h, expected %0b/%0d/%h",
                         c, bus.WE3, bus.AD3, bus.WD3, exp_we, exp_ad, exp_wd);
            else n_pass++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        set_rs('0, '0);
        test_reset();
        test_bypass();
        test_contention();
        test_waw();
        test_x0();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
